// File: rtl/miriscv_prefetch_unit_if.sv
// Request/grant instruction bus between the prefetch unit and instruction memory.
interface miriscv_prefetch_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            instr_req;
  logic [XLEN-1:0] instr_addr;
  logic            instr_gnt;
  logic            instr_rvalid;
  logic [XLEN-1:0] instr_rdata;

  modport master (
    output instr_req,
    output instr_addr,
    input  instr_gnt,
    input  instr_rvalid,
    input  instr_rdata
  );

  modport slave (
    input  instr_req,
    input  instr_addr,
    output instr_gnt,
    output instr_rvalid,
    output instr_rdata
  );
endinterface

// File: rtl/miriscv_prefetch_unit.sv
// miriscv instruction prefetcher: pipelined request/grant fetch with an
// in-order PC tag queue, an instruction queue toward decode and a discard
// counter that drops responses made stale by a redirect.
module miriscv_prefetch_unit #(
  parameter int unsigned XLEN            = 32,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                   clk_i,
  input  logic                   arst_i,
  input  logic [XLEN-1:0]        boot_addr_i,
  miriscv_prefetch_unit_if.master bus,
  input  logic [XLEN-1:0]        cu_pc_bra_i,
  input  logic                   cu_kill_f_i,
  input  logic                   cu_stall_f_i,
  input  logic                   cu_boot_addr_load_en_i,
  output logic [XLEN-1:0]        fetched_pc_addr_o,
  output logic [XLEN-1:0]        fetched_pc_next_addr_o,
  output logic [31:0]            instr_o,
  output logic                   fetch_rvalid_o
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned TAG_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [XLEN-1:0]  req_pc;
  logic [OUT_W-1:0] outstanding;
  logic [OUT_W-1:0] discard;

  logic [XLEN-1:0]  tag_mem [MAX_OUTSTANDING];
  logic [TAG_W-1:0] tag_wr_ptr;
  logic [TAG_W-1:0] tag_rd_ptr;

  logic [XLEN-1:0]  pc_mem    [FIFO_DEPTH];
  logic [31:0]      instr_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] fifo_count;

  logic redirect;
  logic grant;
  logic rsp;
  logic push;
  logic pop;

  function automatic logic [TAG_W-1:0] tag_next(input logic [TAG_W-1:0] p);
    return (p == TAG_W'(MAX_OUTSTANDING - 1)) ? '0 : p + TAG_W'(1);
  endfunction

  // Request only while every in-flight response already has a queue slot reserved
  assign redirect       = cu_boot_addr_load_en_i | cu_kill_f_i;
  assign bus.instr_req  = ~arst_i & ~redirect
                        & (outstanding < OUT_W'(MAX_OUTSTANDING))
                        & ((SUM_W'(fifo_count) + SUM_W'(outstanding)) < SUM_W'(FIFO_DEPTH));
  assign bus.instr_addr = {req_pc[XLEN-1:2], 2'b00};
  assign grant          = bus.instr_req & bus.instr_gnt;
  // Responses with nothing in flight are stale leftovers from before reset
  assign rsp            = bus.instr_rvalid & (outstanding != '0);
  assign push           = rsp & ~redirect & (discard == '0);
  assign fetch_rvalid_o = (fifo_count != '0) & ~cu_stall_f_i & ~redirect;
  assign pop            = fetch_rvalid_o;

  // Head of the queue is always visible, valid or not
  assign fetched_pc_addr_o      = pc_mem[rd_ptr];
  assign fetched_pc_next_addr_o = pc_mem[rd_ptr] + XLEN'(4);
  assign instr_o                = instr_mem[rd_ptr];

  // Fetch PC, in-flight count and count of responses still to be thrown away
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      req_pc      <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding + OUT_W'(grant) - OUT_W'(rsp);
      if (redirect) begin
        req_pc  <= cu_boot_addr_load_en_i ? boot_addr_i : cu_pc_bra_i;
        discard <= outstanding - OUT_W'(rsp);
      end else begin
        if (grant) req_pc <= req_pc + XLEN'(4);
        if (rsp && (discard != '0)) discard <= discard - OUT_W'(1);
      end
    end
  end

  // In-order PC tags of granted requests, retired by every response
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      tag_wr_ptr <= '0;
      tag_rd_ptr <= '0;
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) tag_mem[i] <= '0;
    end else begin
      if (grant) begin
        tag_mem[tag_wr_ptr] <= bus.instr_addr;
        tag_wr_ptr          <= tag_next(tag_wr_ptr);
      end
      if (rsp) tag_rd_ptr <= tag_next(tag_rd_ptr);
    end
  end

  // Instruction queue: flushed on redirect, filled by live responses, drained by decode
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (redirect) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr]    <= tag_mem[tag_rd_ptr];
        instr_mem[wr_ptr] <= bus.instr_rdata[31:0];
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // A response with nothing outstanding means the bus was not reset with the core
  a_no_stale_rvalid: assert property (@(posedge clk_i) disable iff (arst_i)
    bus.instr_rvalid |-> (outstanding != '0));

endmodule

// File: tb/tb_miriscv_prefetch_unit.sv
// Bench for miriscv_prefetch_unit: in-order random-latency memory, and a
// reference model holding in-flight requests and deliverable instructions.
module tb_miriscv_prefetch_unit;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic [31:0] boot_addr = '0;
  logic [31:0] cu_pc_bra = '0;
  logic        kill = 1'b0;
  logic        stall = 1'b0;
  logic        boot_load = 1'b0;
  logic [31:0] fetched_pc, fetched_next, instr;
  logic        fetch_rvalid;

  miriscv_prefetch_unit_if #(.XLEN(XLEN)) bus ();

  miriscv_prefetch_unit #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i                  (clk),
    .arst_i                 (arst),
    .boot_addr_i            (boot_addr),
    .bus                    (bus),
    .cu_pc_bra_i            (cu_pc_bra),
    .cu_kill_f_i            (kill),
    .cu_stall_f_i           (stall),
    .cu_boot_addr_load_en_i (boot_load),
    .fetched_pc_addr_o      (fetched_pc),
    .fetched_pc_next_addr_o (fetched_next),
    .instr_o                (instr),
    .fetch_rvalid_o         (fetch_rvalid)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; bit stale; int ready; } req_t;

  req_t        pending[$];
  logic [31:0] avail[$];
  logic [31:0] exp_req_addr = '0;
  int          cyc = 0;
  int          last_ready = 0;
  int          errors = 0;
  int          checks = 0;
  int unsigned gnt_pct = 0;
  int unsigned lat_min = 1;
  int unsigned lat_max = 1;

  logic        t_arst = 1'b1, t_kill = 1'b0, t_stall = 1'b0, t_boot = 1'b0;
  logic [31:0] t_bra = '0, t_boot_addr = '0;

  logic        s_req, s_gnt, s_rvalid, s_fv, s_redirect, s_boot;
  logic [31:0] s_addr, s_pc, s_next, s_instr, s_bra, s_boot_addr;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_F00D;
  endfunction

  // One clock: drive at negedge, check at negedge+1, advance the model at posedge
  task automatic cycle();
    req_t r;
    int   rdy;
    logic exp_req, exp_fv;
    @(negedge clk);
    arst      = t_arst;
    kill      = t_kill;
    stall     = t_stall;
    boot_load = t_boot;
    cu_pc_bra = t_bra;
    boot_addr = t_boot_addr;
    bus.instr_gnt = ($urandom_range(99) < gnt_pct);
    if (pending.size() != 0 && pending[0].ready <= cyc) begin
      bus.instr_rvalid = 1'b1;
      bus.instr_rdata  = mem_data(pending[0].addr);
    end else begin
      bus.instr_rvalid = 1'b0;
      bus.instr_rdata  = $urandom();
    end
    #1;
    s_req = bus.instr_req;   s_addr = bus.instr_addr;
    s_gnt = bus.instr_gnt;   s_rvalid = bus.instr_rvalid;
    s_fv = fetch_rvalid;     s_pc = fetched_pc;
    s_next = fetched_next;   s_instr = instr;
    s_redirect = kill | boot_load;
    s_boot = boot_load;      s_bra = cu_pc_bra;  s_boot_addr = boot_addr;

    exp_req = !arst && !s_redirect && (pending.size() < MAXO)
            && ((avail.size() + pending.size()) < DEPTH);
    exp_fv  = (avail.size() != 0) && !stall && !s_redirect;
    checks++;
    if (s_req !== exp_req) begin
      errors++; $display("FAIL instr_req cyc=%0d got=%b exp=%b", cyc, s_req, exp_req);
    end
    checks++;
    if (s_addr !== exp_req_addr) begin
      errors++; $display("FAIL instr_addr cyc=%0d got=%h exp=%h", cyc, s_addr, exp_req_addr);
    end
    checks++;
    if (s_fv !== exp_fv) begin
      errors++; $display("FAIL fetch_rvalid cyc=%0d got=%b exp=%b", cyc, s_fv, exp_fv);
    end
    if (avail.size() != 0) begin
      checks++;
      if (s_pc !== avail[0]) begin
        errors++; $display("FAIL head_pc cyc=%0d got=%h exp=%h", cyc, s_pc, avail[0]);
      end
      checks++;
      if (s_instr !== mem_data(avail[0])) begin
        errors++; $display("FAIL head_instr cyc=%0d got=%h exp=%h", cyc, s_instr, mem_data(avail[0]));
      end
      checks++;
      if (s_next !== avail[0] + 32'd4) begin
        errors++; $display("FAIL head_next_pc cyc=%0d got=%h exp=%h", cyc, s_next, avail[0] + 32'd4);
      end
    end

    @(posedge clk);
    if (s_redirect) begin
      avail.delete();
      foreach (pending[i]) pending[i].stale = 1'b1;
      if (s_rvalid) void'(pending.pop_front());
      exp_req_addr = s_boot ? s_boot_addr : s_bra;
    end else begin
      if (exp_fv) void'(avail.pop_front());
      if (s_rvalid) begin
        r = pending.pop_front();
        if (!r.stale) avail.push_back(r.addr);
      end
      if (s_req && s_gnt) begin
        rdy = cyc + int'($urandom_range(lat_max, lat_min));
        if (rdy <= last_ready) rdy = last_ready + 1;
        last_ready = rdy;
        pending.push_back('{s_addr, 1'b0, rdy});
        exp_req_addr = exp_req_addr + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic redirect_to(input logic boot, input logic [31:0] target);
    if (boot) begin t_boot = 1'b1; t_boot_addr = target; end
    else begin t_kill = 1'b1; t_bra = target; end
    cycle();
    t_boot = 1'b0; t_kill = 1'b0;
  endtask

  task automatic test_reset();
    gnt_pct = 0;
    cycle(); cycle();
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", s_req); end
    checks++; if (s_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", s_addr); end
    checks++; if (s_fv !== 1'b0) begin errors++; $display("FAIL reset_fv got=%b exp=0", s_fv); end
    checks++; if (s_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h exp=0", s_instr); end
    checks++; if (s_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", s_pc); end
    checks++; if (s_next !== 32'h4) begin errors++; $display("FAIL reset_next got=%h exp=4", s_next); end
    t_arst = 1'b0;
    cycle();
  endtask

  task automatic test_straight_line();
    gnt_pct = 100; lat_min = 1; lat_max = 1; t_stall = 1'b0;
    redirect_to(1'b1, 32'h100);
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (k < 3) begin
        checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h100 + 32'(4 * k)) begin
          errors++; $display("FAIL straight_req k=%0d got=%b/%h exp=1/%h", k, s_req, s_addr, 32'h100 + 32'(4 * k));
        end
      end
      if (k >= 2) begin
        checks++;
        if (s_fv !== 1'b1 || s_pc !== 32'h100 + 32'(4 * (k - 2)) || s_next !== 32'h104 + 32'(4 * (k - 2))) begin
          errors++; $display("FAIL straight_fetch k=%0d got=%b/%h/%h exp=1/%h/%h", k, s_fv, s_pc, s_next,
                             32'h100 + 32'(4 * (k - 2)), 32'h104 + 32'(4 * (k - 2)));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    t_stall = 1'b1;
    cycle();
    held = s_pc;
    for (int k = 1; k < 10; k++) begin
      cycle();
      checks++;
      if (s_pc !== held || s_fv !== 1'b0) begin
        errors++; $display("FAIL stall_hold k=%0d got=%h/%b exp=%h/0", k, s_pc, s_fv, held);
      end
    end
    checks++;
    if (s_req !== 1'b0) begin errors++; $display("FAIL stall_req_limit got=%b exp=0", s_req); end
    t_stall = 1'b0;
    repeat (20) cycle();
  endtask

  task automatic test_kill();
    logic found;
    gnt_pct = 0;
    for (int i = 0; i < 40 && pending.size() != 0; i++) cycle();
    redirect_to(1'b1, 32'h1000);
    gnt_pct = 100; lat_min = 3; lat_max = 3;
    for (int k = 0; k < 2; k++) begin
      cycle();
      checks++;
      if (!(s_req && s_gnt) || s_addr !== 32'h1000 + 32'(4 * k)) begin
        errors++; $display("FAIL kill_setup k=%0d got=%b/%h exp=1/%h", k, s_req, s_addr, 32'h1000 + 32'(4 * k));
      end
    end
    redirect_to(1'b0, 32'h200);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle();
      if (s_fv) begin
        found = 1'b1;
        checks++;
        if (s_pc !== 32'h200 || s_instr !== mem_data(32'h200)) begin
          errors++; $display("FAIL kill_first got=%h/%h exp=%h/%h", s_pc, s_instr, 32'h200, mem_data(32'h200));
        end
      end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL kill_timeout got=none exp=fetch of 200"); end
  endtask

  task automatic test_boot_over_kill();
    lat_min = 1; lat_max = 2;
    t_kill = 1'b1; t_bra = 32'h200; t_boot = 1'b1; t_boot_addr = 32'h80;
    cycle();
    t_kill = 1'b0; t_boot = 1'b0;
    cycle();
    checks++;
    if (s_addr !== 32'h80) begin errors++; $display("FAIL boot_priority got=%h exp=00000080", s_addr); end
    repeat (10) cycle();
  endtask

  task automatic test_wrap();
    logic        have_prev, req_seen, pc_seen;
    logic [31:0] prev;
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    redirect_to(1'b1, 32'hFFFF_FFF0);
    have_prev = 1'b0; req_seen = 1'b0; pc_seen = 1'b0; prev = '0;
    for (int k = 0; k < 14; k++) begin
      cycle();
      if (s_req && s_gnt) begin
        if (have_prev && prev == 32'hFFFF_FFFC) begin
          req_seen = 1'b1;
          checks++;
          if (s_addr !== 32'h0) begin errors++; $display("FAIL wrap_req got=%h exp=0", s_addr); end
        end
        prev = s_addr; have_prev = 1'b1;
      end
      if (s_fv && s_pc === 32'hFFFF_FFFC) begin
        pc_seen = 1'b1;
        checks++;
        if (s_next !== 32'h0) begin errors++; $display("FAIL wrap_next got=%h exp=0", s_next); end
      end
    end
    checks++;
    if (!(req_seen && pc_seen)) begin
      errors++; $display("FAIL wrap_seen got=%b%b exp=11", req_seen, pc_seen);
    end
  endtask

  task automatic test_async_reset();
    gnt_pct = 100; lat_min = 4; lat_max = 4;
    redirect_to(1'b1, 32'h400);
    for (int i = 0; i < 20 && pending.size() != 2; i++) cycle();
    checks++;
    if (pending.size() != 2) begin errors++; $display("FAIL areset_setup got=%0d exp=2 outstanding", pending.size()); end
    #2;
    arst = 1'b1; t_arst = 1'b1;
    #1;
    checks++; if (bus.instr_req !== 1'b0) begin errors++; $display("FAIL areset_req got=%b exp=0", bus.instr_req); end
    checks++; if (bus.instr_addr !== 32'h0) begin errors++; $display("FAIL areset_addr got=%h exp=0", bus.instr_addr); end
    checks++; if (fetch_rvalid !== 1'b0) begin errors++; $display("FAIL areset_fv got=%b exp=0", fetch_rvalid); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL areset_instr got=%h exp=0", instr); end
    checks++; if (fetched_pc !== 32'h0) begin errors++; $display("FAIL areset_pc got=%h exp=0", fetched_pc); end
    checks++; if (fetched_next !== 32'h4) begin errors++; $display("FAIL areset_next got=%h exp=4", fetched_next); end
    pending.delete(); avail.delete(); exp_req_addr = '0;
    bus.instr_rvalid = 1'b0;
    cycle(); cycle();
    t_arst = 1'b0;
    repeat (10) cycle();
  endtask

  task automatic test_random();
    logic [31:0] tmp;
    int unsigned r;
    gnt_pct = 70; lat_min = 1; lat_max = 4;
    for (int k = 0; k < 1500; k++) begin
      t_stall = ($urandom_range(3) == 0);
      r = $urandom_range(99);
      tmp = $urandom();
      t_kill = (r < 3);
      t_bra = {tmp[31:2], 2'b00};
      tmp = $urandom();
      t_boot = ($urandom_range(99) == 0);
      t_boot_addr = {tmp[31:2], 2'b00};
      cycle();
    end
    t_kill = 1'b0; t_boot = 1'b0; t_stall = 1'b0;
    repeat (20) cycle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.instr_gnt = 1'b0;
    bus.instr_rvalid = 1'b0;
    bus.instr_rdata = '0;
    test_reset();
    test_straight_line();
    test_backpressure();
    test_kill();
    test_boot_over_kill();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
